// File: rtl/set_job_scheduler_if.sv
// Signal bundle between two job requesters, the shared SET engine and the
// response consumer. The scheduler takes the slave view; the surrounding
// system (requesters, engine, consumer) takes the master view.
interface set_job_scheduler_if;
   // requester 0
   logic        req0_valid;
   logic [23:0] req0_central;
   logic [11:0] req0_radius;
   logic [1:0]  req0_mode;
   logic        req0_ready;
   // requester 1
   logic        req1_valid;
   logic [23:0] req1_central;
   logic [11:0] req1_radius;
   logic [1:0]  req1_mode;
   logic        req1_ready;
   // engine side
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy;
   logic        set_valid;
   logic [7:0]  set_candidate;
   // response side
   logic        rsp_valid;
   logic        rsp_id;
   logic [7:0]  rsp_candidate;
   logic        rsp_error;
   logic        rsp_ready;

   modport slave (
      input  req0_valid, req0_central, req0_radius, req0_mode,
      output req0_ready,
      input  req1_valid, req1_central, req1_radius, req1_mode,
      output req1_ready,
      output set_en, set_central, set_radius, set_mode,
      input  set_busy, set_valid, set_candidate,
      output rsp_valid, rsp_id, rsp_candidate, rsp_error,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_central, req0_radius, req0_mode,
      input  req0_ready,
      output req1_valid, req1_central, req1_radius, req1_mode,
      input  req1_ready,
      input  set_en, set_central, set_radius, set_mode,
      output set_busy, set_valid, set_candidate,
      input  rsp_valid, rsp_id, rsp_candidate, rsp_error,
      output rsp_ready
   );
endinterface

// File: rtl/set_job_scheduler.sv
// Round-robin scheduler sharing one SET candidate-counting engine between
// two requesters. One job is in flight at a time: accept, issue to the
// engine with its en/busy handshake, wait for the next result strobe (or a
// watchdog expiry), then hold the response until the consumer takes it.
module set_job_scheduler #(
   parameter int TIMEOUT = 200,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   set_job_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] WD_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

   state_t          state_reg;
   logic            rr_reg;          // requester preferred on a tie
   logic [TO_W-1:0] wd_reg;
   logic [TO_W-1:0] wd_next;
   logic            timeout_hit;
   logic            job_id_reg;

   logic            set_en_reg;
   logic [23:0]     set_central_reg;
   logic [11:0]     set_radius_reg;
   logic [1:0]      set_mode_reg;

   logic            rsp_valid_reg;
   logic            rsp_id_reg;
   logic [7:0]      rsp_candidate_reg;
   logic            rsp_error_reg;

   // Per-requester views so arbitration and muxing can be indexed
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [23:0]     req_central [2];
   logic [11:0]     req_radius  [2];
   logic [1:0]      req_mode    [2];

   logic            grant_any;
   logic            grant_id;

   assign req_valid      = {bus.req1_valid, bus.req0_valid};
   assign req_central[0] = bus.req0_central;
   assign req_central[1] = bus.req1_central;
   assign req_radius[0]  = bus.req0_radius;
   assign req_radius[1]  = bus.req1_radius;
   assign req_mode[0]    = bus.req0_mode;
   assign req_mode[1]    = bus.req1_mode;

   // Pick the only valid requester, or the round-robin favourite on a tie
   always_comb begin
      grant_any = |req_valid;
      if (&req_valid) begin
         grant_id = rr_reg;
      end else begin
         grant_id = req_valid[1];
      end
   end

   // Ready is a one-cycle combinational acknowledge, only ever in IDLE and
   // only for the granted requester, so at most one ready is high at a time
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] &&
                                (grant_id == 1'(gi));
      end
   endgenerate

   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];

   // Watchdog look-ahead: the compare uses the post-increment value so the
   // error response appears exactly TIMEOUT cycles after ISSUE entry. The
   // >= guards the corner where the issue cycle itself lands on the limit.
   always_comb begin
      wd_next     = wd_reg + WD_ONE;
      timeout_hit = (wd_next >= TIMEOUT_C);
   end

   // Job FSM with registered engine and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         rr_reg            <= 1'b0;
         wd_reg            <= '0;
         job_id_reg        <= 1'b0;
         set_en_reg        <= 1'b0;
         set_central_reg   <= '0;
         set_radius_reg    <= '0;
         set_mode_reg      <= '0;
         rsp_valid_reg     <= 1'b0;
         rsp_id_reg        <= 1'b0;
         rsp_candidate_reg <= '0;
         rsp_error_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // engine results arriving here belong to no job and are dropped
               if (grant_any) begin
                  set_central_reg <= req_central[grant_id];
                  set_radius_reg  <= req_radius[grant_id];
                  set_mode_reg    <= req_mode[grant_id];
                  job_id_reg      <= grant_id;
                  wd_reg          <= '0;
                  set_en_reg      <= 1'b1;
                  state_reg       <= ISSUE;
               end
            end

            ISSUE: begin
               // a result strobe here is left over from earlier work; ignore it
               if (!bus.set_busy) begin
                  set_en_reg <= 1'b0;
                  wd_reg     <= wd_next;
                  state_reg  <= WAIT;
               end else if (timeout_hit) begin
                  set_en_reg        <= 1'b0;
                  rsp_valid_reg     <= 1'b1;
                  rsp_id_reg        <= job_id_reg;
                  rsp_candidate_reg <= '0;
                  rsp_error_reg     <= 1'b1;
                  state_reg         <= RESP;
               end else begin
                  wd_reg <= wd_next;
               end
            end

            WAIT: begin
               // a real result beats a watchdog expiry in the same cycle
               if (bus.set_valid) begin
                  rsp_valid_reg     <= 1'b1;
                  rsp_id_reg        <= job_id_reg;
                  rsp_candidate_reg <= bus.set_candidate;
                  rsp_error_reg     <= 1'b0;
                  state_reg         <= RESP;
               end else if (timeout_hit) begin
                  rsp_valid_reg     <= 1'b1;
                  rsp_id_reg        <= job_id_reg;
                  rsp_candidate_reg <= '0;
                  rsp_error_reg     <= 1'b1;
                  state_reg         <= RESP;
               end else begin
                  wd_reg <= wd_next;
               end
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  rr_reg        <= ~rsp_id_reg;
                  state_reg     <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.set_en        = set_en_reg;
   assign bus.set_central   = set_central_reg;
   assign bus.set_radius    = set_radius_reg;
   assign bus.set_mode      = set_mode_reg;
   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_id        = rsp_id_reg;
   assign bus.rsp_candidate = rsp_candidate_reg;
   assign bus.rsp_error     = rsp_error_reg;

endmodule

// File: tb/tb_set_job_scheduler.sv
// Bench for set_job_scheduler: two requesters, a behavioural engine stub
// (normal / hung / hand-driven), and a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_set_job_scheduler;

   localparam int TIMEOUT = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   set_job_scheduler_if bus();

   set_job_scheduler #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int id;
      int cand;
      int err;
      int rise;   // expected cycle of rsp_valid rising, -1 = not checked
   } exp_t;

   exp_t exp_q[$];
   int   grants[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   ready0_cnt    = 0;
   int   eng_valid_cnt = 0;
   int   rise_cyc      = 0;

   // ---------------- engine stub ----------------
   int          eng_mode = 0;      // 0 normal, 1 hung (busy forever), 2 hand-driven
   int          eng_lat  = 5;
   logic [7:0]  eng_base = 8'd29;
   logic        eng_busy_q  = 1'b0;
   logic        eng_valid_q = 1'b0;
   logic [7:0]  eng_cand_q  = 8'd0;
   int          eng_cnt     = 0;
   logic        man_busy  = 1'b0;
   logic        man_valid = 1'b0;
   logic [7:0]  man_cand  = 8'd0;

   function automatic logic [7:0] eng_model(input logic [23:0] c, input logic [11:0] r,
                                             input logic [1:0] m, input logic [7:0] base);
      return c[7:0] + {4'd0, r[3:0]} + {6'd0, m} + base;
   endfunction

   always @(posedge clk) begin
      eng_valid_q <= 1'b0;
      if (eng_mode == 0) begin
         if (!eng_busy_q) begin
            if (bus.set_en) begin
               eng_busy_q <= 1'b1;
               eng_cnt    <= eng_lat;
               eng_cand_q <= eng_model(bus.set_central, bus.set_radius, bus.set_mode, eng_base);
            end
         end else if (eng_cnt == 0) begin
            eng_valid_q <= 1'b1;
            eng_busy_q  <= 1'b0;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   assign bus.set_busy      = (eng_mode == 1) ? 1'b1 : (eng_mode == 2) ? man_busy : eng_busy_q;
   assign bus.set_valid     = (eng_mode == 2) ? man_valid : (eng_mode == 0) ? eng_valid_q : 1'b0;
   assign bus.set_candidate = (eng_mode == 2) ? man_cand : eng_cand_q;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      forever @(posedge clk) cyc++;
   end

   // Response monitor / scoreboard pop
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
         prev_valid = (bus.rsp_valid === 1'b1);
         if (bus.req0_ready === 1'b1) ready0_cnt++;
         if (bus.set_valid === 1'b1) eng_valid_cnt++;
         if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1)
            check_val("both_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
         if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_rsp", 32'(bus.rsp_valid), 0);
            end else begin
               e = exp_q.pop_front();
               $display("rsp id=%0d cand=%0d err=%0d cyc=%0d", bus.rsp_id, bus.rsp_candidate,
                        bus.rsp_error, cyc);
               check_val("rsp_id", 32'(bus.rsp_id), e.id);
               check_val("rsp_candidate", 32'(bus.rsp_candidate), e.cand);
               check_val("rsp_error", 32'(bus.rsp_error), e.err);
               if (e.rise >= 0) check_val("rsp_latency", rise_cyc, e.rise);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Present n0/n1 jobs; each accepted job pushes its expected response.
   task automatic run_jobs(input int n0, input int n1, input bit fixed0, input int ovr,
                           input bit err, input int budget);
      int c0, c1, k, idx;
      bit t0, t1;
      logic [23:0] cen [2];
      logic [11:0] rad [2];
      logic [1:0]  md  [2];
      exp_t e;
      c0 = n0;
      c1 = n1;
      k  = 0;
      for (int i = 0; i < 2; i++) begin
         cen[i] = 24'($urandom);
         rad[i] = 12'($urandom);
         md[i]  = 2'($urandom);
      end
      if (fixed0) begin
         cen[0] = 24'h440000;
         rad[0] = 12'h300;
         md[0]  = 2'd0;
      end
      while ((c0 > 0 || c1 > 0) && k < budget) begin
         bus.req0_valid   = (c0 > 0);
         bus.req0_central = cen[0];
         bus.req0_radius  = rad[0];
         bus.req0_mode    = md[0];
         bus.req1_valid   = (c1 > 0);
         bus.req1_central = cen[1];
         bus.req1_radius  = rad[1];
         bus.req1_mode    = md[1];
         @(negedge clk);
         t0 = bus.req0_valid && (bus.req0_ready === 1'b1);
         t1 = bus.req1_valid && (bus.req1_ready === 1'b1);
         if (t0 || t1) begin
            idx    = t0 ? 0 : 1;
            e.id   = idx;
            e.err  = err;
            e.cand = err ? 0 : (ovr >= 0 ? ovr : int'(eng_model(cen[idx], rad[idx], md[idx], eng_base)));
            e.rise = err ? cyc + 1 + TIMEOUT : -1;
            exp_q.push_back(e);
            grants.push_back(idx);
            $display("accept req%0d central=%h radius=%h mode=%0d cyc=%0d", idx, cen[idx],
                     rad[idx], md[idx], cyc);
         end
         @(posedge clk);
         #1;
         if (t0) begin
            c0--;
            cen[0] = 24'($urandom);
            rad[0] = 12'($urandom);
            md[0]  = 2'($urandom);
         end
         if (t1) begin
            c1--;
            cen[1] = 24'($urandom);
            rad[1] = 12'($urandom);
            md[1]  = 2'($urandom);
         end
         k++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (c0 > 0 || c1 > 0) check_val("accept_timeout", c0 + c1, 0);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_val("drain", exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_set_en"},        32'(bus.set_en), 0);
      check_val({tag, "_set_central"},   32'(bus.set_central), 0);
      check_val({tag, "_set_radius"},    32'(bus.set_radius), 0);
      check_val({tag, "_set_mode"},      32'(bus.set_mode), 0);
      check_val({tag, "_rsp_valid"},     32'(bus.rsp_valid), 0);
      check_val({tag, "_rsp_id"},        32'(bus.rsp_id), 0);
      check_val({tag, "_rsp_candidate"}, 32'(bus.rsp_candidate), 0);
      check_val({tag, "_rsp_error"},     32'(bus.rsp_error), 0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k, v0;
      int exp_order [4];
      exp_order = '{0, 1, 0, 1};
      bus.req0_valid = 1'b0; bus.req0_central = '0; bus.req0_radius = '0; bus.req0_mode = '0;
      bus.req1_valid = 1'b0; bus.req1_central = '0; bus.req1_radius = '0; bus.req1_mode = '0;
      bus.rsp_ready  = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      check_val("reset_req0_ready", 32'(bus.req0_ready), 0);
      check_val("reset_req1_ready", 32'(bus.req1_ready), 0);
      @(posedge clk);
      #1;

      // 1: single job on the normal engine
      ready0_cnt = 0;
      run_jobs(1, 0, 1'b1, -1, 1'b0, 50);
      drain(200);
      check_val("single_req0_ready_pulses", ready0_cnt, 1);

      // 2: contention from reset, then alternation
      pulse_reset();
      grants.delete();
      run_jobs(2, 2, 1'b0, -1, 1'b0, 300);
      drain(200);
      check_val("grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check_val($sformatf("grant_order_%0d", i), grants[i], exp_order[i]);

      // 3: stale engine strobe during ISSUE is ignored
      eng_mode  = 2;
      man_busy  = 1'b1;
      man_valid = 1'b0;
      run_jobs(0, 1, 1'b0, 17, 1'b0, 20);
      man_valid = 1'b1;
      man_cand  = 8'd99;
      @(negedge clk);
      check_val("stale_set_en_issue", 32'(bus.set_en), 1);
      @(posedge clk);
      #1;
      man_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      man_busy = 1'b0;
      @(posedge clk);
      #1;
      man_busy = 1'b1;
      @(negedge clk);
      check_val("stale_set_en_wait", 32'(bus.set_en), 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      man_cand  = 8'd17;
      man_valid = 1'b1;
      @(posedge clk);
      #1;
      man_valid = 1'b0;
      man_busy  = 1'b0;
      drain(50);
      eng_mode = 0;

      // 4: hung engine -> watchdog error, then normal job
      eng_mode = 1;
      run_jobs(1, 0, 1'b0, -1, 1'b1, 20);
      drain(TIMEOUT + 50);
      eng_mode = 0;
      run_jobs(0, 1, 1'b0, -1, 1'b0, 50);
      drain(100);

      // 5: response backpressure
      bus.rsp_ready = 1'b0;
      run_jobs(1, 0, 1'b0, -1, 1'b0, 50);
      k = 0;
      @(negedge clk);
      while (bus.rsp_valid !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_val("bp_rsp_seen", 32'(bus.rsp_valid), 1);
      @(posedge clk);
      #1;
      bus.req1_valid   = 1'b1;
      bus.req1_central = 24'h123456;
      check_val("bp_queue", exp_q.size(), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            check_val("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check_val("bp_rsp_id", 32'(bus.rsp_id), exp_q[0].id);
            check_val("bp_rsp_candidate", 32'(bus.rsp_candidate), exp_q[0].cand);
            check_val("bp_rsp_error", 32'(bus.rsp_error), exp_q[0].err);
         end
         check_val("bp_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
         @(posedge clk);
         #1;
      end
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("bp_rsp_valid_fall", 32'(bus.rsp_valid), 0);
      check_val("bp_drained", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // 6: reset while waiting for the engine
      eng_lat = 20;
      run_jobs(1, 0, 1'b0, -1, 1'b0, 50);
      k = 0;
      @(negedge clk);
      while (bus.set_en === 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("rst_reached_wait", 32'(bus.set_en), 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      exp_q.delete();
      v0 = eng_valid_cnt;
      pulse_reset();
      @(negedge clk);
      check_all_zero("midrst");
      repeat (30) @(posedge clk);
      #1;
      check_val("rst_engine_valid_seen", 32'(eng_valid_cnt > v0), 1);
      check_val("rst_no_rsp", 32'(bus.rsp_valid), 0);
      eng_lat = 5;
      run_jobs(1, 1, 1'b0, -1, 1'b0, 100);
      drain(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got cyc=%0d expected finish", cyc);
      $fatal(1, "global timeout");
   end

endmodule
